// File: rtl/debug_display_ctrl.sv
// debug_display_ctrl
//
// Board-level consumer of the processor debug outputs. Scans a 4-digit,
// active-low seven-segment display with one 16-bit half of either the PC or
// the selected register value. It also debounces a push button into a
// single-cycle step pulse used as the processor clock enable.
//
// Ports:
//   clk         system clock (single domain)
//   reset       synchronous, active-high reset
//   step_btn    raw asynchronous push button, 1 = pressed
//   show_pc     1 = display pc_value, 0 = display reg_value
//   show_upper  1 = display bits [31:16], 0 = bits [15:0]
//   pc_value    processor PCout
//   reg_value   processor RegOut
//   step_pulse  one-cycle pulse per accepted press
//   an          digit enables, active-low, an[0] = rightmost digit
//   seg         segments gfedcba, active-low
//   dp          decimal point, active-low
module debug_display_ctrl #(
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        show_pc,
  input  logic        show_upper,
  input  logic [31:0] pc_value,
  input  logic [31:0] reg_value,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [RW-1:0] RCNT_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitPress, StHeld, StWaitRelease} state_t;

  // Button synchronizer
  logic r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM
  state_t        r_state;
  logic [DW-1:0] r_dcnt;
  logic          r_step_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_dcnt       <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_sync2) begin
            r_state <= StWaitPress;
            r_dcnt  <= '0;
          end
        end
        StWaitPress: begin
          if (!r_sync2) begin
            r_state <= StIdle;
          end else if (r_dcnt == DCNT_MAX) begin
            // Only the press path pulses; re-entry from StWaitRelease does not.
            r_state      <= StHeld;
            r_step_pulse <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        StHeld: begin
          if (!r_sync2) begin
            r_state <= StWaitRelease;
            r_dcnt  <= '0;
          end
        end
        StWaitRelease: begin
          if (r_sync2) begin
            r_state <= StHeld;
          end else if (r_dcnt == DCNT_MAX) begin
            r_state <= StIdle;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign step_pulse = r_step_pulse;

  // Scan counters and per-frame snapshot
  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_digit;
  logic [15:0]   r_snap;
  logic [31:0]   w_sel_word;
  logic [15:0]   w_sel_half;

  assign w_sel_word = show_pc ? pc_value : reg_value;
  assign w_sel_half = show_upper ? w_sel_word[31:16] : w_sel_word[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rcnt  <= '0;
      r_digit <= 2'd0;
      r_snap  <= 16'h0000;
    end else if (r_rcnt == RCNT_MAX) begin
      r_rcnt  <= '0;
      r_digit <= r_digit + 2'd1;
      // Load only at the frame boundary so a frame never mixes two values.
      if (r_digit == 2'd3) begin
        r_snap <= w_sel_half;
      end
    end else begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end

  // Glyph decode of the nibble for the current digit
  logic [3:0] w_nibble;
  logic [6:0] w_glyph;

  assign w_nibble = r_snap[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_glyph = 7'b1111111;
    case (w_nibble)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b0000011;
      4'hC: w_glyph = 7'b1000110;
      4'hD: w_glyph = 7'b0100001;
      4'hE: w_glyph = 7'b0000110;
      4'hF: w_glyph = 7'b0001110;
      default: w_glyph = 7'b1111111;
    endcase
  end

  // Registered display outputs, one cycle behind digit/snap
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_digit);
      r_seg <= w_glyph;
      r_dp  <= ~((r_digit == 2'd3) && show_upper);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_debug_display_ctrl.sv
module tb_debug_display_ctrl;

  localparam int unsigned REFRESH_DIV     = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;
  localparam int unsigned FRAME           = 4 * REFRESH_DIV;

  logic        clk;
  logic        reset;
  logic        step_btn;
  logic        show_pc;
  logic        show_upper;
  logic [31:0] pc_value;
  logic [31:0] reg_value;
  logic        step_pulse;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  debug_display_ctrl #(
    .REFRESH_DIV     (REFRESH_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .step_btn   (step_btn),
    .show_pc    (show_pc),
    .show_upper (show_upper),
    .pc_value   (pc_value),
    .reg_value  (reg_value),
    .step_pulse (step_pulse),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboards: display expectations keyed by cycle, and cycles where a pulse is due.
  typedef struct {
    int         at;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_exp_t;

  disp_exp_t disp_q[$];
  int        pulse_q[$];
  disp_exp_t m_e;
  logic      p_exp;

  task automatic push_disp(input int at, input logic [3:0] a, input logic [6:0] s, input logic d);
    disp_exp_t e;
    e.at  = at;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    disp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (disp_q.size() > 0) begin
      if (disp_q[0].at < cyc) begin
        check_eq("disp_missed", cyc, disp_q[0].at);
        void'(disp_q.pop_front());
      end else if (disp_q[0].at == cyc) begin
        m_e = disp_q.pop_front();
        check_eq("an", 32'(an), 32'(m_e.an));
        check_eq("seg", 32'(seg), 32'(m_e.seg));
        check_eq("dp", 32'(dp), 32'(m_e.dp));
      end
    end
  end

  always @(negedge clk) begin
    p_exp = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
    if (p_exp) void'(pulse_q.pop_front());
    check_eq("step_pulse", 32'(step_pulse), 32'(p_exp));
  end

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    g = 7'b1111111;
    case (h)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  4'hF: g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] a;
    a = 4'b1111;
    case (d)
      0: a = 4'b1110;
      1: a = 4'b1101;
      2: a = 4'b1011;
      3: a = 4'b0111;
      default: a = 4'b1111;
    endcase
    return a;
  endfunction

  function automatic logic [15:0] sel_half(input logic p, input logic u,
                                           input logic [31:0] pcv, input logic [31:0] rv);
    logic [31:0] w;
    w = p ? pcv : rv;
    return u ? w[31:16] : w[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_btn(input logic v, input int cycles);
    step_btn = v;
    repeat (cycles) tick();
  endtask

  logic [15:0] m_snap;
  int          base;
  int          t;
  int          d;

  initial begin
    reset      = 1'b1;
    step_btn   = 1'b0;
    show_pc    = 1'b1;
    show_upper = 1'b0;
    pc_value   = 32'h1234ABCD;
    reg_value  = 32'h0;

    // Reset held for 3 edges: outputs at reset values.
    for (int i = 1; i <= 3; i++) push_disp(i, 4'b1111, 7'b1111111, 1'b1);
    repeat (3) tick();
    reset = 1'b0;
    base  = cyc;

    // Four frames of scanning; selection switches mid-frame 3.
    m_snap = 16'h0000;
    for (int n = 1; n <= 4 * int'(FRAME); n++) begin
      if (n == 38) begin
        show_upper = 1'b1;
        show_pc    = 1'b0;
        reg_value  = 32'h00FF0000;
      end
      d = ((n - 1) / int'(REFRESH_DIV)) % 4;
      push_disp(base + n, an_of(d), glyph(m_snap[4*d +: 4]), !(d == 3 && show_upper));
      if (n % int'(FRAME) == 0) m_snap = sel_half(show_pc, show_upper, pc_value, reg_value);
      tick();
    end

    // Clean press held 40 cycles, then a re-press after 12 low cycles.
    t = cyc;
    pulse_q.push_back(t + 11);
    drive_btn(1'b1, 40);
    drive_btn(1'b0, 12);
    t = cyc;
    pulse_q.push_back(t + 11);
    drive_btn(1'b1, 20);
    drive_btn(1'b0, 15);

    // Short highs never reach the end of the debounce window.
    drive_btn(1'b1, 1);
    drive_btn(1'b0, 12);
    drive_btn(1'b1, 3);
    drive_btn(1'b0, 12);
    drive_btn(1'b1, 7);
    drive_btn(1'b0, 12);

    // A 3-cycle dropout while held must not produce a second pulse.
    t = cyc;
    pulse_q.push_back(t + 11);
    drive_btn(1'b1, 20);
    drive_btn(1'b0, 3);
    drive_btn(1'b1, 20);
    drive_btn(1'b0, 15);

    // Reset partway through the debounce window restarts the whole count.
    t = cyc;
    drive_btn(1'b1, 8);
    reset = 1'b1;
    push_disp(t + 9, 4'b1111, 7'b1111111, 1'b1);
    tick();
    reset = 1'b0;
    pulse_q.push_back(t + 20);
    drive_btn(1'b1, 25);
    drive_btn(1'b0, 15);

    repeat (2) tick();
    check_eq("disp_q_drained", 32'(disp_q.size()), 32'd0);
    check_eq("pulse_q_drained", 32'(pulse_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
